// File: rtl/panel_loader_if.sv
// Host-side handshake and front-panel drive signals of the PDP-8 panel loader.
interface panel_loader_if;
  logic        start;
  logic [11:0] start_addr;
  logic [12:0] word_count;
  logic [11:0] word_data;
  logic        word_valid;
  logic        word_ready;
  logic        abort;
  logic [12:0] panel_sw;
  logic        panel_load_pc;
  logic        panel_deposit;
  logic        busy;
  logic        done;

  modport master (
    output start, start_addr, word_count, word_data, word_valid, abort,
    input  word_ready, panel_sw, panel_load_pc, panel_deposit, busy, done
  );

  modport slave (
    input  start, start_addr, word_count, word_data, word_valid, abort,
    output word_ready, panel_sw, panel_load_pc, panel_deposit, busy, done
  );
endinterface

// File: rtl/panel_loader.sv
// Loads a memory image into a PDP-8 by sequencing the front-panel switches:
// Load PC, one Deposit per word, then Load PC again so the PC points at the image.
module panel_loader #(
  parameter int unsigned HOLD_CYCLES = 10
) (
  input  logic          clk,
  input  logic          btnCpuReset,
  panel_loader_if.slave bus
);

  typedef enum logic [3:0] {
    IDLE, SET_PC, ASSERT_PC, RELEASE_PC, WAIT_WORD, SET_DEP, ASSERT_DEP,
    RELEASE_DEP, SET_RST, ASSERT_RST, RELEASE_RST, DONE
  } state_t;

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  state_t      state, state_nxt;
  logic [7:0]  hold_cnt;
  logic [11:0] addr_q, data_q;
  logic [12:0] remain_q;
  logic [12:0] sw_q, sw_nxt;
  logic        load_pc_q, deposit_q, ready_q, busy_q, done_q;
  logic        hold_done, xfer;

  assign bus.panel_sw      = sw_q;
  assign bus.panel_load_pc = load_pc_q;
  assign bus.panel_deposit = deposit_q;
  assign bus.word_ready    = ready_q;
  assign bus.busy          = busy_q;
  assign bus.done          = done_q;

  always_comb begin
    state_nxt = state;
    xfer      = 1'b0;
    hold_done = (hold_cnt == '0);
    if (state != IDLE && bus.abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:        if (bus.start && !bus.abort) state_nxt = SET_PC;
        SET_PC:      if (hold_done) state_nxt = ASSERT_PC;
        ASSERT_PC:   if (hold_done) state_nxt = RELEASE_PC;
        RELEASE_PC:  if (hold_done) state_nxt = (remain_q == '0) ? DONE : WAIT_WORD;
        WAIT_WORD: begin
          // word_ready is high exactly while in WAIT_WORD, so valid alone completes the handshake
          if (bus.word_valid) begin
            xfer      = 1'b1;
            state_nxt = SET_DEP;
          end
        end
        SET_DEP:     if (hold_done) state_nxt = ASSERT_DEP;
        ASSERT_DEP:  if (hold_done) state_nxt = RELEASE_DEP;
        RELEASE_DEP: if (hold_done) state_nxt = (remain_q != '0) ? WAIT_WORD : SET_RST;
        SET_RST:     if (hold_done) state_nxt = ASSERT_RST;
        ASSERT_RST:  if (hold_done) state_nxt = RELEASE_RST;
        RELEASE_RST: if (hold_done) state_nxt = DONE;
        DONE:        state_nxt = IDLE;
        default:     state_nxt = IDLE;
      endcase
    end

    // Switch register only changes on entry to a SET_ phase, so it is stable while a button is down
    sw_nxt = sw_q;
    if (state == IDLE && state_nxt == SET_PC) sw_nxt = {1'b0, bus.start_addr};
    if (state_nxt == SET_RST && state != SET_RST) sw_nxt = {1'b0, addr_q};
    if (xfer) sw_nxt = {1'b0, bus.word_data};
  end

  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state     <= IDLE;
      hold_cnt  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      remain_q  <= '0;
      sw_q      <= '0;
      load_pc_q <= 1'b0;
      deposit_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state)   hold_cnt <= HOLD_RELOAD;
      else if (hold_cnt != '0)  hold_cnt <= hold_cnt - 8'd1;
      if (state == IDLE && state_nxt == SET_PC) begin
        addr_q   <= bus.start_addr;
        remain_q <= bus.word_count;
      end
      if (xfer) begin
        data_q   <= bus.word_data;
        remain_q <= remain_q - 13'd1;
      end
      sw_q      <= sw_nxt;
      load_pc_q <= (state_nxt == ASSERT_PC) || (state_nxt == ASSERT_RST);
      deposit_q <= (state_nxt == ASSERT_DEP);
      ready_q   <= (state_nxt == WAIT_WORD);
      busy_q    <= (state_nxt != IDLE);
      done_q    <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_panel_loader.sv
// Scoreboard bench for panel_loader: stimulus queues expected panel events,
// a monitor reconstructs button pulses and done strobes and compares them.
module tb_panel_loader;
  localparam int unsigned HOLD = 2;

  localparam int EV_LOAD = 0;
  localparam int EV_DEP  = 1;
  localparam int EV_DONE = 2;

  typedef struct {
    int          kind;
    logic [12:0] sw;
    int          width;
  } ev_t;

  logic clk = 1'b0;
  logic btnCpuReset;
  always #5 clk = ~clk;

  panel_loader_if bus ();

  panel_loader #(.HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .btnCpuReset (btnCpuReset),
    .bus         (bus)
  );

  ev_t         exp_q[$];
  logic [11:0] src_q[$];
  int          errors = 0;
  int          checks = 0;
  bit          feed_en = 1'b0;
  bit          feed_pend = 1'b0;
  int          ready_cnt = 0;
  int          done_cnt = 0;
  int          pulse_width = 0;
  int          pulse_kind = 0;
  logic [12:0] pulse_sw = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0o required %0o", name, act, req);
    end
  endtask

  task automatic push_ev(input int kind, input logic [12:0] sw, input int width);
    ev_t e;
    e.kind  = kind;
    e.sw    = sw;
    e.width = width;
    exp_q.push_back(e);
  endtask

  task automatic report_ev(input int kind, input logic [12:0] sw, input int width);
    ev_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event: got kind %0d sw %0o width %0d required none", kind, sw, width);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", kind, e.kind);
      if (e.kind != EV_DONE) begin
        chk("event_sw", sw, e.sw);
        chk("event_width", width, e.width);
      end
    end
  endtask

  // Monitor: rebuilds pulses from the registered outputs, sampled on the falling edge
  always @(negedge clk) begin
    if (bus.word_ready === 1'b1) ready_cnt++;
    if (bus.panel_load_pc === 1'b1 || bus.panel_deposit === 1'b1) begin
      chk("buttons_exclusive", {31'b0, bus.panel_load_pc & bus.panel_deposit}, 32'd0);
      if (pulse_width > 0) begin
        chk("sw_stable_while_pressed", bus.panel_sw, pulse_sw);
      end else begin
        pulse_sw   = bus.panel_sw;
        pulse_kind = (bus.panel_load_pc === 1'b1) ? EV_LOAD : EV_DEP;
      end
      pulse_width++;
    end else if (pulse_width > 0) begin
      report_ev(pulse_kind, pulse_sw, pulse_width);
      pulse_width = 0;
    end
    if (bus.done === 1'b1) begin
      done_cnt++;
      report_ev(EV_DONE, '0, 1);
    end
  end

  // Word source: presents the head of src_q, pops it after each accepted transfer
  initial begin
    bus.word_valid = 1'b0;
    bus.word_data  = '0;
    forever begin
      @(negedge clk);
      if (feed_pend && src_q.size() > 0) void'(src_q.pop_front());
      bus.word_valid = feed_en && (src_q.size() > 0);
      bus.word_data  = (src_q.size() > 0) ? src_q[0] : 12'd0;
      feed_pend      = bus.word_valid && (bus.word_ready === 1'b1);
    end
  end

  task automatic start_load(input logic [11:0] addr, input logic [12:0] count);
    @(negedge clk);
    bus.start_addr = addr;
    bus.word_count = count;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  // Returns the cycle index (1 = first cycle after the start edge) in which done is seen
  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (bus.done !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (bus.done !== 1'b1) begin
      chk("done_timeout", 32'd0, 32'd1);
      cyc = -1;
    end
  endtask

  task automatic expect_full_load(input logic [11:0] addr, input logic [11:0] words[$]);
    push_ev(EV_LOAD, {1'b0, addr}, HOLD);
    foreach (words[i]) push_ev(EV_DEP, {1'b0, words[i]}, HOLD);
    push_ev(EV_LOAD, {1'b0, addr}, HOLD);
    push_ev(EV_DONE, '0, 1);
  endtask

  initial begin
    int          cyc;
    int          n;
    int          bad;
    int          snap;
    logic [11:0] w[$];

    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.start_addr = '0;
    bus.word_count = '0;
    btnCpuReset = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sw", bus.panel_sw, 32'd0);
    chk("reset_load_pc", bus.panel_load_pc, 32'd0);
    chk("reset_deposit", bus.panel_deposit, 32'd0);
    chk("reset_ready", bus.word_ready, 32'd0);
    chk("reset_busy", bus.busy, 32'd0);
    chk("reset_done", bus.done, 32'd0);
    btnCpuReset = 1'b1;
    repeat (2) @(negedge clk);

    // Three-word image at 0200, source always valid
    w = '{12'o7300, 12'o1205, 12'o7402};
    src_q = w;
    feed_en = 1'b1;
    expect_full_load(12'o0200, w);
    start_load(12'o0200, 13'd3);
    chk("busy_after_start", bus.busy, 32'd1);
    chk("sw_after_start", bus.panel_sw, 32'o0200);
    wait_done(200, cyc);
    chk("done_cycle_3words", cyc, 32'd34);
    @(negedge clk);
    chk("busy_after_done", bus.busy, 32'd0);
    chk("events_seen_3words", exp_q.size(), 32'd0);

    // Empty image: single Load PC, no handshake at all
    snap = ready_cnt;
    push_ev(EV_LOAD, 13'o7777, HOLD);
    push_ev(EV_DONE, '0, 1);
    start_load(12'o7777, 13'd0);
    wait_done(100, cyc);
    chk("done_cycle_empty", cyc, 32'd7);
    chk("ready_never_high_empty", ready_cnt - snap, 32'd0);
    @(negedge clk);
    chk("events_seen_empty", exp_q.size(), 32'd0);

    // Source stalls for 50 cycles in WAIT_WORD
    feed_en = 1'b0;
    w = '{12'o4321, 12'o1234};
    src_q = w;
    expect_full_load(12'o0400, w);
    start_load(12'o0400, 13'd2);
    n = 0;
    while (bus.word_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_reached", bus.word_ready, 32'd1);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.word_ready !== 1'b1 || bus.busy !== 1'b1 || bus.panel_load_pc !== 1'b0 ||
          bus.panel_deposit !== 1'b0 || bus.panel_sw !== 13'o0400 || bus.done !== 1'b0) bad++;
    end
    chk("stall_static_cycles_bad", bad, 32'd0);
    feed_en = 1'b1;
    wait_done(200, cyc);
    @(negedge clk);
    chk("events_seen_stall", exp_q.size(), 32'd0);

    // Abort during the second deposit pulse
    w = '{12'o1111, 12'o2222, 12'o3333};
    src_q = w;
    push_ev(EV_LOAD, 13'o1000, HOLD);
    push_ev(EV_DEP, 13'o1111, HOLD);
    push_ev(EV_DEP, 13'o2222, 1);
    start_load(12'o1000, 13'd3);
    n = 0;
    cyc = 0;
    snap = 0;
    while (n < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.panel_deposit === 1'b1 && snap == 0) n++;
      snap = (bus.panel_deposit === 1'b1) ? 1 : 0;
    end
    chk("second_deposit_reached", n, 32'd2);
    snap = done_cnt;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    src_q.delete();
    chk("abort_deposit_low", bus.panel_deposit, 32'd0);
    chk("abort_busy_low", bus.busy, 32'd0);
    chk("abort_ready_low", bus.word_ready, 32'd0);
    repeat (10) @(negedge clk);
    chk("abort_no_done", done_cnt - snap, 32'd0);
    chk("abort_stays_idle", bus.busy, 32'd0);

    // start together with abort in IDLE is ignored
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    repeat (5) @(negedge clk);
    chk("start_abort_idle_ignored", bus.busy, 32'd0);

    w = '{12'o5555};
    src_q = w;
    expect_full_load(12'o0020, w);
    start_load(12'o0020, 13'd1);
    wait_done(100, cyc);
    chk("done_cycle_after_abort", cyc, 32'd20);
    @(negedge clk);
    chk("events_seen_abort", exp_q.size(), 32'd0);

    // Asynchronous reset while Load PC is pressed
    push_ev(EV_LOAD, 13'o6543, 1);
    start_load(12'o6543, 13'd1);
    n = 0;
    while (bus.panel_load_pc !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("load_pc_reached", bus.panel_load_pc, 32'd1);
    #1 btnCpuReset = 1'b0;
    #1;
    chk("async_rst_sw", bus.panel_sw, 32'd0);
    chk("async_rst_load_pc", bus.panel_load_pc, 32'd0);
    chk("async_rst_deposit", bus.panel_deposit, 32'd0);
    chk("async_rst_ready", bus.word_ready, 32'd0);
    chk("async_rst_busy", bus.busy, 32'd0);
    chk("async_rst_done", bus.done, 32'd0);
    start_load(12'o0777, 13'd2);
    repeat (3) @(negedge clk);
    chk("start_in_reset_ignored", bus.busy, 32'd0);
    btnCpuReset = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_after_reset", bus.busy, 32'd0);
    chk("no_press_after_reset", bus.panel_load_pc, 32'd0);

    w = '{12'o0007};
    src_q = w;
    expect_full_load(12'o0100, w);
    start_load(12'o0100, 13'd1);
    wait_done(100, cyc);
    chk("done_cycle_after_reset", cyc, 32'd20);
    repeat (2) @(negedge clk);
    chk("events_seen_final", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end
endmodule
